// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared types and defaults for the FFT frame sequencer
package fft_seq_pkg;
  localparam int DEF_SAMPLE_W = 24;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, BUSY} bank_state_t;
  typedef enum logic {W_IDLE, W_FILL} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_OFFER, R_BUSY} rd_state_t;
endpackage

// File: rtl/sample_bank_ram.sv
// sample_bank_ram: simple dual-port two-bank sample RAM, address {bank, addr}, registered read
module sample_bank_ram
  import fft_seq_pkg::*;
#(
  parameter int W  = DEF_SAMPLE_W,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: ping-pong capture of audio strobes into frames offered to the FFT by valid/ready
// Define FFT_SEQ_STATS_EN to add the saturating overrun_count port.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int FRAME_LEN = 256,
  parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                advance,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                enable,
  output logic                frame_valid,
  output logic                frame_bank,
  input  logic                frame_ready,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data,
  input  logic                frame_done,
  output logic                overrun,
  output logic [15:0]         frame_count
`ifdef FFT_SEQ_STATS_EN
  ,output logic [15:0]        overrun_count
`endif
);
  logic [2:0] adv_sync;
  logic ev, has_empty, claim, we, wsel, full0, full1, sel;
  logic [ADDR_W-1:0] wptr, waddr;
  bank_state_t bank_st [2];
  wr_state_t w_st;
  rd_state_t r_st;
  logic first_full, wbank;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) adv_sync <= '0;
    else adv_sync <= {adv_sync[1:0], advance};
  always_comb begin
    ev = adv_sync[1] & ~adv_sync[2];
    has_empty = bank_st[0] == EMPTY || bank_st[1] == EMPTY;
    claim = bank_st[0] != EMPTY;
    we = ev & enable & (w_st == W_FILL || has_empty);
    wsel = w_st == W_FILL ? wbank : claim;
    waddr = w_st == W_FILL ? wptr : '0;
    full0 = bank_st[0] == FULL;
    full1 = bank_st[1] == FULL;
    sel = full0 && full1 ? first_full : full1;
    frame_valid = r_st == R_OFFER;
  end
  // Write and read FSMs never touch the same bank in one cycle: one owns FILLING, the other FULL/BUSY.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      w_st <= W_IDLE;
      r_st <= R_IDLE;
      wbank <= 1'b0;
      wptr <= '0;
      first_full <= 1'b0;
      frame_bank <= 1'b0;
      overrun <= 1'b0;
      frame_count <= '0;
    end else begin
      overrun <= ev & enable & (w_st == W_IDLE) & ~has_empty;
      if (!enable) begin
        if (w_st == W_FILL) bank_st[wbank] <= EMPTY;
        w_st <= W_IDLE;
        wptr <= '0;
      end else if (ev && w_st == W_IDLE && has_empty) begin
        bank_st[claim] <= FILLING;
        wbank <= claim;
        wptr <= ADDR_W'(1);
        w_st <= W_FILL;
      end else if (ev && w_st == W_FILL) begin
        wptr <= wptr + 1'b1;
        if (&wptr) begin
          bank_st[wbank] <= FULL;
          w_st <= W_IDLE;
          frame_count <= frame_count + 16'd1;
          if (bank_st[!wbank] != FULL) first_full <= wbank;
        end
      end
      case (r_st)
        R_IDLE:
          if (full0 || full1) begin
            frame_bank <= sel;
            r_st <= R_OFFER;
          end
        R_OFFER:
          if (frame_ready) begin
            bank_st[frame_bank] <= BUSY;
            r_st <= R_BUSY;
          end
        R_BUSY:
          if (frame_done) begin
            bank_st[frame_bank] <= EMPTY;
            r_st <= R_IDLE;
          end
        default: r_st <= R_IDLE;
      endcase
    end
`ifdef FFT_SEQ_STATS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) overrun_count <= '0;
    else if (overrun && overrun_count != 16'hFFFF) overrun_count <= overrun_count + 16'd1;
`endif
  sample_bank_ram #(.W(SAMPLE_W), .AW(ADDR_W + 1)) u_ram (
    .clk(clk),
    .reset_n(reset_n),
    .we(we),
    .waddr({wsel, waddr}),
    .wdata(sample_in),
    .re(r_st != R_IDLE),
    .raddr({frame_bank, rd_addr}),
    .rdata(rd_data)
  );
endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Collects 24-bit audio samples from the audio driver's `advance` strobe into a two-bank (ping-pong) frame memory and offers each completed frame to the FFT engine through a valid/ready handshake. The FFT engine reads the offered bank through a registered read port and releases it with `frame_done`. The block sits between `audio_driver` and the FFT core. It decouples the 48 kHz sample stream from FFT processing and counts samples lost when the FFT falls behind.

## Interface
- `SAMPLE_W`, 24: sample width in bits.
- `FRAME_LEN`, 256: samples per frame; must be a power of two, at least 4.
- `ADDR_W`, `$clog2(FRAME_LEN)`: read-address width.

- `clk`  in  1  system clock (CLOCK_50 domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `advance`  in  1  sample strobe from the audio driver; asynchronous to `clk`.
- `sample_in`  in  SAMPLE_W  left-channel ADC sample; stable while `advance` is high.
- `enable`  in  1  capture enable.
- `frame_valid`  out  1  a full bank is offered.
- `frame_bank`  out  1  index of the offered or busy bank.
- `frame_ready`  in  1  FFT accepts the offer.
- `rd_addr`  in  ADDR_W  FFT read address within `frame_bank`.
- `rd_data`  out  SAMPLE_W  registered read data.
- `frame_done`  in  1  single-cycle pulse that releases the busy bank.
- `overrun`  out  1  single-cycle pulse for each dropped sample.
- `frame_count`  out  16  completed frames, wrapping.
- `overrun_count`  out  16  dropped samples, saturating; present only under `FFT_SEQ_STATS_EN`.

## Operation
- **Bank states** (`bank_state_t`): EMPTY, FILLING, FULL, BUSY. Both banks are EMPTY at reset.
- **Strobe synchronisation:** `advance` passes through a 2-flop synchroniser followed by a rising-edge detector. Each detected edge produces exactly one sample event.
- **Write FSM, W_IDLE → W_FILL:**
  - In W_IDLE, with `enable` high, a sample event claims the lowest-indexed EMPTY bank. The bank becomes FILLING, the sample is written at address 0, and the FSM moves to W_FILL.
  - In W_FILL, each sample event writes at `wptr`, then `wptr` increments.
  - On the write at address FRAME_LEN-1, the bank becomes FULL, `frame_count` increments, and the FSM returns to W_IDLE.
- **Overrun:** a sample event in W_IDLE with no EMPTY bank is dropped. `overrun` pulses for it.
- **Disable:** `enable` low for one cycle returns a FILLING bank to EMPTY and clears `wptr`. FULL and BUSY banks are untouched.
- **Read FSM, R_IDLE → R_OFFER → R_BUSY → R_IDLE:**
  - R_OFFER is entered when any bank is FULL. If both banks are FULL, the one filled first is chosen.
  - `frame_valid` is high only in R_OFFER, and `frame_bank` holds steady while `frame_valid` is high.
  - `frame_valid && frame_ready` marks the bank BUSY and moves to R_BUSY.
  - In R_BUSY, `frame_done` sets the bank EMPTY and returns to R_IDLE.
  - `frame_done` outside R_BUSY is ignored.
- **Frame order:** frames are offered strictly in fill order.
- **Read port:** `rd_data` returns memory[`frame_bank`][`rd_addr`] and is valid in R_OFFER and R_BUSY. In other states it holds its last value.

## Timing
- **Reset values:** `frame_valid`=0, `frame_bank`=0, `rd_data`=0, `overrun`=0, `frame_count`=0, `overrun_count`=0. Both FSMs are idle.
- **Sample latency:** the sample is written on the 3rd `clk` rising edge after `advance` rises. `sample_in` is captured on that same edge.
- **Offer latency:** `frame_valid` rises 1 cycle after the final sample write.
- **Back-to-back frames:** the next `frame_valid` may rise 1 cycle after the `frame_done` cycle.
- **Read latency:** `rd_data` is valid 1 cycle after `rd_addr`, with full throughput.
- **Simultaneous events:**
  - If `frame_done` arrives in the same cycle as a sample event that finds no EMPTY bank, the sample is dropped. Release takes effect at the end of the cycle.
  - A fill completing in the same cycle as `frame_done` is offered no earlier than the following cycle.
- **Mid-operation reset:** all state returns to reset values immediately. Memory contents are don't-care.

## Configuration
- **`FFT_SEQ_STATS_EN` defined:**
  - The `overrun_count` port and register exist.
  - The count increments with each `overrun` pulse and saturates at 16'hFFFF.
- **Not defined:**
  - The port is absent.
  - `overrun` and `frame_count` remain.

## Structure
- **Package `fft_seq_pkg`:** holds the `bank_state_t` enum, the write-FSM and read-FSM state enums, and the `SAMPLE_W` default.
- **Sub-module `sample_bank_ram`:** a simple dual-port RAM of 2×FRAME_LEN × SAMPLE_W words with a registered read. Its address is {bank, addr}. It maps to M10K.
- **Top level:** the synchroniser, edge detector, both FSMs and the counters live in `fft_frame_sequencer`.

## Test plan
- **Basic fill and read:** FRAME_LEN=8, 8 strobes with samples 1..8 → `frame_valid`=1, `frame_bank`=0. After the handshake, reading addresses 0..7 returns 1..8, one cycle delayed. `frame_count`=1.
- **Ping-pong:** 16 strobes, FFT holds bank 0 BUSY → bank 1 fills to FULL. `frame_done` leads to bank 1 being offered the next cycle.
- **Overrun:** both banks FULL, 3 more strobes → 3 `overrun` pulses. `overrun_count`=3 (stats build). Existing frame data is unchanged.
- **Disable mid-frame:** 5 strobes, `enable` low, then 8 strobes → the first frame offered contains only the last 8 samples, in bank 0.
- **Reset mid-frame:** `reset_n` low during R_BUSY → all outputs return to reset values. A subsequent fill starts at bank 0.
- **Spurious release:** `frame_done` pulses in R_IDLE → no state change, `frame_count` unchanged.
